// File: rtl/memory_access.sv
// memory_access: pipeline stage between execute and writeback.
// Performs the data-memory access for loads and stores over a req/ack bus,
// stalls upstream while a request is outstanding, and presents a registered
// instruction bundle to writeback. Load data is right-aligned. Sign and zero
// extension happen in writeback.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_*                  instruction bundle from execute
//                         (in_res is the byte address for loads and stores)
//   stall                 high while a memory request is outstanding
//   mem_req/we/addr/wdata/wstrb   data-memory request, driven from hold registers
//   mem_ack, mem_rdata    request completion and load word
//   out_*                 registered instruction bundle to writeback
//   out_mem_rd            right-aligned load data, 0 for non-loads
//   out_misalign          one-cycle flag for a misaligned access
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_noop,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_res,
  input  logic [31:0] in_rs2,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_noop,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic [31:0] out_res,
  output logic [31:0] out_mem_rd,
  output logic        out_misalign
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_BUSY   = 1'b1;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [0:0]  r_state;

  // Hold registers: the accepted memory op, stable for the whole request.
  logic [6:0]  r_h_opcode;
  logic [2:0]  r_h_funct3;
  logic [4:0]  r_h_rd;
  logic [31:0] r_h_imm;
  logic [31:0] r_h_res;
  logic [31:0] r_h_wdata;
  logic [3:0]  r_h_wstrb;
  logic        r_h_we;

  // Output registers.
  logic        r_out_noop;
  logic [6:0]  r_out_opcode;
  logic [2:0]  r_out_funct3;
  logic [4:0]  r_out_rd;
  logic [31:0] r_out_imm;
  logic [31:0] r_out_res;
  logic [31:0] r_out_mem_rd;
  logic        r_out_misalign;

  logic        w_busy;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_opc;
  logic        w_bad_funct3;
  logic        w_size_mis;
  logic        w_misalign;
  logic        w_start;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load_data;

  assign w_busy       = (r_state == S_BUSY);
  assign w_mem_opc    = (in_opcode == OP_LOAD) || (in_opcode == OP_STORE);
  assign w_is_load    = (in_opcode == OP_LOAD) && (in_funct3 != 3'd3) &&
                        (in_funct3 != 3'd6) && (in_funct3 != 3'd7);
  assign w_is_store   = (in_opcode == OP_STORE) && (in_funct3 <= 3'd2);
  assign w_bad_funct3 = w_mem_opc && !(w_is_load || w_is_store);

  // funct3[1:0] encodes the access size for every valid load/store
  // (LBU/LHU share it with LB/LH).
  always_comb begin
    w_size_mis = 1'b0;
    case (in_funct3[1:0])
      2'd1:    w_size_mis = in_res[0];
      2'd2:    w_size_mis = |in_res[1:0];
      default: w_size_mis = 1'b0;
    endcase
  end

  assign w_misalign = (w_is_load || w_is_store) && w_size_mis;
  assign w_start    = !w_busy && !in_noop && (w_is_load || w_is_store) && !w_misalign;

  always_comb begin
    w_wdata = in_rs2;
    w_wstrb = 4'b1111;
    case (in_funct3[1:0])
      2'd0: begin
        w_wdata = {4{in_rs2[7:0]}};
        w_wstrb = 4'b0001 << in_res[1:0];
      end
      2'd1: begin
        w_wdata = {2{in_rs2[15:0]}};
        w_wstrb = 4'b0011 << in_res[1:0];
      end
      default: begin
        w_wdata = in_rs2;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  assign w_load_data = mem_rdata >> {r_h_res[1:0], 3'b000};

  // Bus side is a pure decode of state and hold registers, so nothing here
  // depends combinationally on mem_ack or on in_* while a request is open.
  assign stall     = w_busy;
  assign mem_req   = w_busy;
  assign mem_we    = w_busy & r_h_we;
  assign mem_addr  = {r_h_res[31:2], 2'b00};
  assign mem_wdata = r_h_wdata;
  assign mem_wstrb = w_busy ? r_h_wstrb : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_h_opcode     <= '0;
      r_h_funct3     <= '0;
      r_h_rd         <= '0;
      r_h_imm        <= '0;
      r_h_res        <= '0;
      r_h_wdata      <= '0;
      r_h_wstrb      <= '0;
      r_h_we         <= 1'b0;
      r_out_noop     <= 1'b1;
      r_out_opcode   <= '0;
      r_out_funct3   <= '0;
      r_out_rd       <= '0;
      r_out_imm      <= '0;
      r_out_res      <= '0;
      r_out_mem_rd   <= '0;
      r_out_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_h_opcode     <= in_opcode;
            r_h_funct3     <= in_funct3;
            r_h_rd         <= in_rd;
            r_h_imm        <= in_imm;
            r_h_res        <= in_res;
            r_h_wdata      <= w_wdata;
            r_h_wstrb      <= w_is_store ? w_wstrb : 4'b0000;
            r_h_we         <= w_is_store;
            r_out_noop     <= 1'b1;
            r_out_misalign <= 1'b0;
            r_out_mem_rd   <= '0;
            r_state        <= S_BUSY;
          end else begin
            // Bad funct3 and misaligned ops are forwarded as bubbles.
            r_out_noop     <= in_noop | w_bad_funct3 | w_misalign;
            r_out_misalign <= ~in_noop & w_misalign;
            r_out_opcode   <= in_opcode;
            r_out_funct3   <= in_funct3;
            r_out_rd       <= in_rd;
            r_out_imm      <= in_imm;
            r_out_res      <= in_res;
            r_out_mem_rd   <= '0;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_out_noop     <= 1'b0;
            r_out_misalign <= 1'b0;
            r_out_opcode   <= r_h_opcode;
            r_out_funct3   <= r_h_funct3;
            r_out_rd       <= r_h_rd;
            r_out_imm      <= r_h_imm;
            r_out_res      <= r_h_res;
            // Only loads and stores are ever held, so !we means load.
            r_out_mem_rd   <= r_h_we ? 32'd0 : w_load_data;
            r_state        <= S_IDLE;
          end else begin
            r_out_noop     <= 1'b1;
            r_out_misalign <= 1'b0;
            r_out_mem_rd   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_noop     = r_out_noop;
  assign out_opcode   = r_out_opcode;
  assign out_funct3   = r_out_funct3;
  assign out_rd       = r_out_rd;
  assign out_imm      = r_out_imm;
  assign out_res      = r_out_res;
  assign out_mem_rd   = r_out_mem_rd;
  assign out_misalign = r_out_misalign;

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: reset checks, a directed vector table,
// hand-written multi-cycle sequences, and a randomized instruction stream
// checked against a transaction-level reference model.
module tb_memory_access;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_imm, in_res, in_rs2;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_noop;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd;
  logic [31:0] out_imm, out_res, out_mem_rd;
  logic        out_misalign;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst_n(rst_n),
    .in_noop(in_noop), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_imm(in_imm), .in_res(in_res), .in_rs2(in_rs2),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_noop(out_noop), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_rd(out_rd),
    .out_imm(out_imm), .out_res(out_res), .out_mem_rd(out_mem_rd), .out_misalign(out_misalign)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic        noop;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm, res, rs2, rdata;
    int unsigned k;        // ack arrives in the k-th busy cycle
  } instr_t;

  typedef struct {
    logic        bubble;
    logic        noop, mis;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm, res, mem_rd;
  } out_t;

  typedef struct {
    instr_t      in;
    logic        ack;
    logic [31:0] rdata;
    logic        busy, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    out_t        nxt;      // expected out_* after this cycle's edge
  } cyc_t;

  typedef struct {
    instr_t      i;
    logic        acc;
    logic        exp_noop, exp_mis;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_mem_rd;
  } vec_t;

  cyc_t trace[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic noop, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] res,
                                input logic [31:0] rs2, input logic [31:0] rdata,
                                input int unsigned k);
    instr_t i;
    i.noop = noop; i.op = op; i.f3 = f3; i.rd = rd; i.imm = 32'h0000_0F00 | 32'(rd);
    i.res = res; i.rs2 = rs2; i.rdata = rdata; i.k = k;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    in_noop = i.noop; in_opcode = i.op; in_funct3 = i.f3; in_rd = i.rd;
    in_imm = i.imm; in_res = i.res; in_rs2 = i.rs2;
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int unsigned size_bytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic logic valid_op(input instr_t i);
    if (i.op == OP_LOAD)  return (i.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (i.op == OP_STORE) return (i.f3 inside {3'd0, 3'd1, 3'd2});
    return 1'b0;
  endfunction

  function automatic logic is_mis(input instr_t i);
    return valid_op(i) && ((i.res % size_bytes(i.f3)) != 0);
  endfunction

  function automatic logic needs_access(input instr_t i);
    return !i.noop && valid_op(i) && !is_mis(i);
  endfunction

  function automatic out_t bubble_out();
    out_t o;
    o.bubble = 1'b1; o.noop = 1'b1; o.mis = 1'b0; o.op = '0; o.f3 = '0; o.rd = '0;
    o.imm = '0; o.res = '0; o.mem_rd = '0;
    return o;
  endfunction

  function automatic out_t pass_out(input instr_t i);
    out_t o;
    o.bubble = 1'b0;
    o.noop   = i.noop || ((i.op == OP_LOAD || i.op == OP_STORE) && !valid_op(i)) || is_mis(i);
    o.mis    = !i.noop && is_mis(i);
    o.op = i.op; o.f3 = i.f3; o.rd = i.rd; o.imm = i.imm; o.res = i.res; o.mem_rd = '0;
    return o;
  endfunction

  function automatic out_t done_out(input instr_t i);
    out_t o;
    o.bubble = 1'b0; o.noop = 1'b0; o.mis = 1'b0;
    o.op = i.op; o.f3 = i.f3; o.rd = i.rd; o.imm = i.imm; o.res = i.res;
    o.mem_rd = (i.op == OP_LOAD) ? (i.rdata >> (8 * (i.res % 4))) : 32'd0;
    return o;
  endfunction

  // Lane b carries byte (b mod size) of rs2; strobe covers size bytes at the offset.
  task automatic store_lanes(input instr_t i, output logic [31:0] wd, output logic [3:0] ws);
    int unsigned nb;
    logic [31:0] m;
    nb = size_bytes(i.f3);
    wd = '0;
    for (int b = 0; b < 4; b++)
      wd = wd | (((i.rs2 >> (8 * (b % nb))) & 32'hFF) << (8 * b));
    m  = ((32'd1 << nb) - 32'd1) << (i.res % 4);
    ws = m[3:0];
  endtask

  task automatic build_trace(input instr_t lst[$]);
    trace.delete();
    for (int n = 0; n < lst.size(); n++) begin
      cyc_t c;
      c.in = lst[n]; c.ack = 1'($urandom_range(1)); c.rdata = $urandom;
      c.busy = 1'b0; c.we = 1'b0; c.addr = '0; c.wdata = '0; c.wstrb = '0;
      if (!needs_access(lst[n])) begin
        c.nxt = pass_out(lst[n]);
        trace.push_back(c);
      end else begin
        c.nxt = bubble_out();
        trace.push_back(c);
        for (int j = 1; j <= int'(lst[n].k); j++) begin
          cyc_t b;
          b.in    = (n + 1 < lst.size()) ? lst[n+1] : mk(1'b0, OP_IMM, 3'd0, 5'd1, 32'h1, 32'h0, 32'h0, 1);
          b.busy  = 1'b1;
          b.we    = (lst[n].op == OP_STORE);
          b.addr  = lst[n].res - (lst[n].res % 4);
          store_lanes(lst[n], b.wdata, b.wstrb);
          b.ack   = (j == int'(lst[n].k));
          b.rdata = b.ack ? lst[n].rdata : $urandom;
          b.nxt   = b.ack ? done_out(lst[n]) : bubble_out();
          trace.push_back(b);
        end
      end
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, " out_noop"}, out_noop, e.noop);
    chk({tag, " out_misalign"}, out_misalign, e.mis);
    if (!e.bubble) begin
      chk({tag, " out_opcode"}, out_opcode, e.op);
      chk({tag, " out_funct3"}, out_funct3, e.f3);
      chk({tag, " out_rd"}, out_rd, e.rd);
      chk({tag, " out_imm"}, out_imm, e.imm);
      chk({tag, " out_res"}, out_res, e.res);
      chk({tag, " out_mem_rd"}, out_mem_rd, e.mem_rd);
    end
  endtask

  // Entered #1 after a clock edge with the DUT idle.
  task automatic run_trace(input string tag);
    foreach (trace[c]) begin
      drive(trace[c].in);
      mem_ack = trace[c].ack; mem_rdata = trace[c].rdata;
      #1;
      chk({tag, " stall"}, stall, trace[c].busy);
      chk({tag, " mem_req"}, mem_req, trace[c].busy);
      if (trace[c].busy) begin
        chk({tag, " mem_addr"}, mem_addr, trace[c].addr);
        chk({tag, " mem_we"}, mem_we, trace[c].we);
        if (trace[c].we) begin
          chk({tag, " mem_wdata"}, mem_wdata, trace[c].wdata);
          chk({tag, " mem_wstrb"}, mem_wstrb, trace[c].wstrb);
        end
      end
      @(posedge clk); #1;
      check_out(tag, trace[c].nxt);
    end
    mem_ack = 1'b0;
  endtask

  // Directed single-instruction vector against hand-computed expectations.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    drive(v.i); mem_ack = 1'b0; mem_rdata = v.i.rdata;
    #1;
    chk({t, " stall_idle"}, stall, 1'b0);
    chk({t, " req_idle"}, mem_req, 1'b0);
    @(posedge clk); #1;
    if (!v.acc) begin
      chk({t, " req_none"}, mem_req, 1'b0);
      chk({t, " out_noop"}, out_noop, v.exp_noop);
      chk({t, " out_misalign"}, out_misalign, v.exp_mis);
      chk({t, " out_mem_rd"}, out_mem_rd, v.exp_mem_rd);
      if (!v.exp_noop) begin
        chk({t, " out_rd"}, out_rd, v.i.rd);
        chk({t, " out_res"}, out_res, v.i.res);
        chk({t, " out_opcode"}, out_opcode, v.i.op);
      end
    end else begin
      chk({t, " bubble"}, out_noop, 1'b1);
      for (int j = 1; j <= int'(v.i.k); j++) begin
        chk({t, " stall_busy"}, stall, 1'b1);
        chk({t, " req_busy"}, mem_req, 1'b1);
        chk({t, " mem_addr"}, mem_addr, v.exp_addr);
        chk({t, " mem_we"}, mem_we, v.i.op == OP_STORE);
        if (v.i.op == OP_STORE) begin
          chk({t, " mem_wdata"}, mem_wdata, v.exp_wdata);
          chk({t, " mem_wstrb"}, mem_wstrb, v.exp_wstrb);
        end
        mem_ack = (j == int'(v.i.k));
        @(posedge clk); #1;
        if (j < int'(v.i.k)) chk({t, " bubble_wait"}, out_noop, 1'b1);
      end
      mem_ack = 1'b0;
      chk({t, " out_noop_done"}, out_noop, 1'b0);
      chk({t, " out_misalign"}, out_misalign, 1'b0);
      chk({t, " out_funct3"}, out_funct3, v.i.f3);
      chk({t, " out_rd"}, out_rd, v.i.rd);
      chk({t, " out_res"}, out_res, v.i.res);
      chk({t, " out_mem_rd"}, out_mem_rd, v.exp_mem_rd);
      chk({t, " stall_fall"}, stall, 1'b0);
    end
  endtask

  function automatic vec_t V(input instr_t i, input logic acc, input logic en, input logic em,
                             input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] es,
                             input logic [31:0] er);
    vec_t v;
    v.i = i; v.acc = acc; v.exp_noop = en; v.exp_mis = em;
    v.exp_addr = ea; v.exp_wdata = ew; v.exp_wstrb = es; v.exp_mem_rd = er;
    return v;
  endfunction

  initial begin
    vec_t   tbl[$];
    instr_t lst[$];

    tbl.push_back(V(mk(0, OP_IMM,   3'd0, 5'd5,  32'h1234, 0, 0, 1),            0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd0, 5'd3,  32'h103, 0, 32'hAABBCCDD, 3),  1, 0, 0, 32'h100, 0, 4'b0000, 32'h000000AA));
    tbl.push_back(V(mk(0, OP_STORE, 3'd1, 5'd0,  32'h202, 32'h0000BEEF, 0, 1),  1, 0, 0, 32'h200, 32'hBEEFBEEF, 4'b1100, 0));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd2, 5'd4,  32'h301, 0, 0, 1),             0, 1, 1, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(0, OP_REG,   3'd0, 5'd9,  32'hFFFFFFFF, 0, 0, 1),        0, 0, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd1, 5'd6,  32'h102, 0, 32'h11223344, 2),  1, 0, 0, 32'h100, 0, 4'b0000, 32'h00001122));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd4, 5'd7,  32'h001, 0, 32'hAABBCCDD, 1),  1, 0, 0, 32'h000, 0, 4'b0000, 32'h00AABBCC));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd5, 5'd8,  32'h003, 0, 0, 1),             0, 1, 1, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd5, 5'd8,  32'h106, 0, 32'h8899AABB, 1),  1, 0, 0, 32'h104, 0, 4'b0000, 32'h00008899));
    tbl.push_back(V(mk(0, OP_STORE, 3'd0, 5'd0,  32'h041, 32'h123456A5, 0, 2),  1, 0, 0, 32'h040, 32'hA5A5A5A5, 4'b0010, 0));
    tbl.push_back(V(mk(0, OP_STORE, 3'd2, 5'd0,  32'h080, 32'hDEADBEEF, 0, 1),  1, 0, 0, 32'h080, 32'hDEADBEEF, 4'b1111, 0));
    tbl.push_back(V(mk(0, OP_STORE, 3'd2, 5'd0,  32'h082, 32'hDEADBEEF, 0, 1),  0, 1, 1, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd3, 5'd2,  32'h100, 0, 0, 1),             0, 1, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(0, OP_STORE, 3'd4, 5'd0,  32'h100, 32'h1, 0, 1),         0, 1, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(1, OP_LOAD,  3'd2, 5'd2,  32'h100, 0, 0, 1),             0, 1, 0, 0, 0, 4'b0000, 0));
    tbl.push_back(V(mk(0, OP_LOAD,  3'd2, 5'd10, 32'h204, 0, 32'hCAFEF00D, 4),  1, 0, 0, 32'h204, 0, 4'b0000, 32'hCAFEF00D));
    tbl.push_back(V(mk(0, OP_STORE, 3'd1, 5'd0,  32'h200, 32'hFFFF1234, 0, 1),  1, 0, 0, 32'h200, 32'h12341234, 4'b0011, 0));

    // Reset state.
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    drive(mk(0, OP_IMM, 3'd0, 5'd0, 0, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_noop", out_noop, 1'b1);
    chk("rst out_rd", out_rd, 5'd0);
    chk("rst out_res", out_res, 32'd0);
    chk("rst out_mem_rd", out_mem_rd, 32'd0);
    chk("rst out_misalign", out_misalign, 1'b0);
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_wstrb", mem_wstrb, 4'd0);
    chk("rst stall", stall, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[n]) run_vec(tbl[n], n);

    // SW stalled while the following ADD waits on the inputs.
    lst.delete();
    lst.push_back(mk(0, OP_STORE, 3'd2, 5'd0, 32'h500, 32'h01020304, 0, 3));
    lst.push_back(mk(0, OP_REG, 3'd0, 5'd12, 32'h77, 0, 0, 1));
    build_trace(lst);
    run_trace("b2b");

    // Reset while busy abandons the request; a late ack is ignored.
    drive(mk(0, OP_LOAD, 3'd2, 5'd3, 32'h400, 0, 32'h12345678, 1));
    mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("rstbusy req_before", mem_req, 1'b1);
    drive(mk(0, OP_IMM, 3'd0, 5'd7, 32'h55, 0, 0, 1));
    @(posedge clk); #1;
    chk("rstbusy still_busy", stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy mem_req", mem_req, 1'b0);
    chk("rstbusy out_noop", out_noop, 1'b1);
    chk("rstbusy stall", stall, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rstbusy late_ack out_noop", out_noop, 1'b0);
    chk("rstbusy late_ack out_rd", out_rd, 5'd7);
    chk("rstbusy late_ack out_res", out_res, 32'h55);
    chk("rstbusy late_ack out_mem_rd", out_mem_rd, 32'd0);
    chk("rstbusy late_ack mem_req", mem_req, 1'b0);

    // Randomized stream against the reference model.
    lst.delete();
    for (int n = 0; n < 150; n++) begin
      instr_t r;
      int unsigned sel;
      sel     = $urandom_range(9);
      r.op    = (sel < 4) ? OP_LOAD : (sel < 7) ? OP_STORE : (sel == 7) ? OP_IMM :
                (sel == 8) ? OP_REG : 7'($urandom);
      r.f3    = 3'($urandom_range(7));
      r.rd    = 5'($urandom);
      r.imm   = $urandom;
      r.res   = $urandom;
      r.rs2   = $urandom;
      r.rdata = $urandom;
      r.k     = $urandom_range(4, 1);
      r.noop  = ($urandom_range(9) == 0);
      lst.push_back(r);
    end
    build_trace(lst);
    run_trace("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
